// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter family: FSM states,
// broadcast default, destination-field extraction and onehot decoding.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER
    } arb_state_e;

    localparam logic [7:0] DEFAULT_BCAST_ID = 8'hFF;
    localparam int MAX_PKT   = 256;
    localparam int MAX_PORTS = 64;

    // Destination field occupies [msb -: id_w]; callers zero-extend the packet.
    function automatic logic [31:0] extract_id(input logic [MAX_PKT-1:0] pkt,
                                               input int unsigned msb,
                                               input int unsigned id_w);
        logic [31:0] field_mask;
        field_mask = (id_w >= 32) ? '1 : ((32'd1 << id_w) - 32'd1);
        return 32'(pkt >> (msb + 1 - id_w)) & field_mask;
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant picker: round-robin from the slot after ptr, or
// fixed priority (lowest index) when prio_mode is set.
module rr_grant
    import bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    input  logic             prio_mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int cand;

    // Walk the candidates in priority order and keep the first pending one.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = 0; k < N; k++) begin
            cand = prio_mode ? k : (int'(ptr) + 1 + k) % N;
            if (!grant_valid && ((pending & (N'(1) << cand)) != '0)) begin
                grant       = N'(1) << cand;
                grant_valid = 1'b1;
            end
        end
        grant_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(grant)));
    end

endmodule

// File: rtl/bus_rr_arbiter_bcast.sv
// Single-bus arbiter: picks a pending device, pops one packet and delivers it
// to one destination or broadcasts it, honouring per-destination full.
module bus_rr_arbiter_bcast
    import bus_arb_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BCAST_ID  = ID_W'(DEFAULT_BCAST_ID),
    parameter int              PRIO_MODE = 0,
    parameter int              CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0]           full,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    arb_state_e         state, next_state;
    logic [drvrs-1:0]   grant_q, grant_d;
    logic [drvrs-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic [drvrs-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [pckg_sz-1:0] popped_pkt;
    logic [31:0]        dest_id;

    rr_grant #(
        .N     (drvrs),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .pending     (pndng),
        .ptr         (ptr_q),
        .prio_mode   (PRIO_MODE != 0),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign popped_pkt = pckg_sz'(D_pop >> (32'(gidx_q) * pckg_sz));
    assign dest_id    = extract_id(MAX_PKT'(popped_pkt), pckg_sz - 1, ID_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            mask_q  <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(drvrs - 1);
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state   <= next_state;
            grant_q <= grant_d;
            mask_q  <= mask_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    // Grant is frozen in IDLE; the packet is decoded as it is popped.
    always_comb begin
        next_state = state;
        grant_d    = grant_q;
        mask_d     = mask_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        pkt_d      = pkt_q;
        drop_d     = drop_q;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_d    = arb_grant;
                    gidx_d     = arb_idx;
                    next_state = POP;
                end
            end
            POP: begin
                pkt_d = popped_pkt;
                ptr_d = gidx_q;
                if (dest_id == 32'(BCAST_ID)) begin
                    mask_d     = ~grant_q;
                    next_state = (|(~grant_q)) ? DELIVER : IDLE;
                end else if (dest_id < 32'(drvrs)) begin
                    mask_d     = drvrs'(1) << dest_id;
                    next_state = DELIVER;
                end else begin
                    if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
                    next_state = IDLE;
                end
            end
            DELIVER: begin
                // Targets that were pushed this cycle leave the mask.
                mask_d = mask_q & full;
                if ((mask_q & full) == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign pop      = (state == POP) ? grant_q : '0;
    assign push     = (state == DELIVER) ? (mask_q & ~full) : '0;
    assign D_push   = {drvrs{pkt_q}};
    assign busy     = (state != IDLE);
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_arbiter_bcast.sv
// Bench for bus_rr_arbiter_bcast: a round-robin instance and a fixed-priority
// instance with a narrow drop counter, checked against a transaction model.
module tb_bus_rr_arbiter_bcast;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng_a, pndng_b, full;
    logic [63:0] d_pop;
    logic [3:0]  pop_a, push_a, pop_b, push_b;
    logic [63:0] d_push_a, d_push_b;
    logic        busy_a, busy_b;
    logic [15:0] drop_a;
    logic [3:0]  drop_b;
    logic        sel;

    logic [3:0]  obs_pop, obs_push;
    logic [63:0] obs_dpush;
    logic        obs_busy;
    logic [15:0] obs_drop;

    int checks = 0;
    int errors = 0;
    int ptr_m[2]    = '{3, 3};
    int drops_m[2]  = '{0, 0};
    int cnt_max[2]  = '{65535, 15};
    int mode_m[2]   = '{0, 1};

    always #5 clk = ~clk;

    bus_rr_arbiter_bcast #(
        .drvrs(4), .pckg_sz(16), .ID_W(8), .BCAST_ID(8'hFF), .PRIO_MODE(0), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .pndng(pndng_a), .D_pop(d_pop), .full(full),
        .pop(pop_a), .push(push_a), .D_push(d_push_a), .busy(busy_a), .drop_cnt(drop_a)
    );

    bus_rr_arbiter_bcast #(
        .drvrs(4), .pckg_sz(16), .ID_W(8), .BCAST_ID(8'hFF), .PRIO_MODE(1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .pndng(pndng_b), .D_pop(d_pop), .full(full),
        .pop(pop_b), .push(push_b), .D_push(d_push_b), .busy(busy_b), .drop_cnt(drop_b)
    );

    assign obs_pop   = sel ? pop_b    : pop_a;
    assign obs_push  = sel ? push_b   : push_a;
    assign obs_dpush = sel ? d_push_b : d_push_a;
    assign obs_busy  = sel ? busy_b   : busy_a;
    assign obs_drop  = sel ? {12'b0, drop_b} : drop_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected winner straight from the arbitration rule.
    function automatic int winner(input int s, input logic [3:0] pv);
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (mode_m[s] != 0) ? k : (ptr_m[s] + 1 + k) % 4;
            if (pv[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand_data();
        logic [63:0] d;
        int r;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 5);
            if (r < 4)       d[i*16+8 +: 8] = 8'(r);
            else if (r == 4) d[i*16+8 +: 8] = 8'hFF;
            else             d[i*16+8 +: 8] = 8'($urandom_range(4, 254));
            d[i*16 +: 8] = 8'($urandom);
        end
        return d;
    endfunction

    task automatic txn(input int s, input logic [3:0] pv, input logic [63:0] data,
                       input logic [3:0] full_v, input int full_cycles);
        int          w;
        logic [15:0] pkt;
        logic [7:0]  dest;
        logic [3:0]  rem;
        @(negedge clk);
        sel   = s[0];
        d_pop = data;
        full  = full_v;
        if (s == 1) pndng_b = pv; else pndng_a = pv;
        w = winner(s, pv);
        @(posedge clk); #1;
        if (w < 0) begin
            chk("idle_busy", 64'(obs_busy), 64'd0);
            return;
        end
        chk("pop_grant", 64'(obs_pop), 64'(4'b1 << w));
        chk("push_in_pop", 64'(obs_push), 64'd0);
        chk("busy_pop", 64'(obs_busy), 64'd1);
        pndng_a = 4'b0;
        pndng_b = 4'b0;
        ptr_m[s] = w;
        pkt  = data[w*16 +: 16];
        dest = pkt[15:8];
        @(posedge clk); #1;
        chk("pop_once", 64'(obs_pop), 64'd0);
        if (dest == 8'hFF) rem = 4'hF & ~(4'b1 << w);
        else if (dest < 8'd4) rem = 4'b1 << dest;
        else begin
            if (drops_m[s] < cnt_max[s]) drops_m[s]++;
            chk("drop_busy", 64'(obs_busy), 64'd0);
            chk("drop_push", 64'(obs_push), 64'd0);
            chk("drop_cnt", 64'(obs_drop), 64'(drops_m[s]));
            full = 4'b0;
            return;
        end
        for (int c = 0; c < 20 && rem != 4'b0; c++) begin
            full = (c < full_cycles) ? full_v : 4'b0;
            #1;
            chk("push", 64'(obs_push), 64'(rem & ~full));
            chk("busy_deliver", 64'(obs_busy), 64'd1);
            if ((rem & ~full) != 4'b0) chk("d_push", obs_dpush, {4{pkt}});
            rem = rem & full;
            @(posedge clk); #1;
        end
        chk("done_busy", 64'(obs_busy), 64'd0);
        chk("done_push", 64'(obs_push), 64'd0);
        full = 4'b0;
    endtask

    initial begin
        logic [63:0] d;
        reset   = 1'b1;
        sel     = 1'b0;
        pndng_a = 4'hF;
        pndng_b = 4'hF;
        full    = 4'b0;
        d_pop   = '0;

        // Reset held with everything pending: outputs stay quiet.
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_pop", 64'(pop_a), 64'd0);
            chk("rst_push", 64'(push_a), 64'd0);
            chk("rst_busy", 64'(busy_a), 64'd0);
            chk("rst_drop", 64'(drop_a), 64'd0);
            chk("rst_pop_b", 64'(pop_b), 64'd0);
        end
        @(negedge clk);
        reset   = 1'b0;
        pndng_a = 4'b0;
        pndng_b = 4'b0;

        // Round-robin rotation with all ports pending, then wrap to port 0.
        d = {16'h01D3, 16'h00C2, 16'h03B1, 16'h02A0};
        repeat (5) txn(0, 4'hF, d, 4'b0, 0);

        // Single unicast from port 1 to port 2.
        txn(0, 4'b0010, {16'h0000, 16'h0000, 16'h02AB, 16'h0000}, 4'b0, 0);

        // Broadcast from port 0 with port 2 blocked for four cycles.
        txn(0, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFF55}, 4'b0100, 4);

        // Misaddressed packet from port 3 is dropped.
        txn(0, 4'b1000, {16'h0711, 16'h0000, 16'h0000, 16'h0000}, 4'b0, 0);

        // Fixed priority always picks port 0.
        repeat (4) txn(1, 4'hF, d, 4'b0, 0);

        // Narrow counter saturates.
        repeat (20) txn(1, 4'b1000, {16'h0722, 48'h0}, 4'b0, 0);
        chk("drop_sat", 64'(drop_b), 64'd15);

        // Randomized traffic on both instances.
        repeat (60) begin
            txn($urandom_range(0, 1), 4'($urandom), rand_data(), 4'($urandom),
                $urandom_range(0, 3));
        end

        // Reset in the middle of a blocked delivery abandons the packet.
        @(negedge clk);
        sel     = 1'b0;
        d_pop   = {16'h0000, 16'h02CD, 16'h0000, 16'h0000};
        full    = 4'b0100;
        pndng_a = 4'b0100;
        @(posedge clk); #1;
        pndng_a = 4'b0;
        @(posedge clk); #1;
        chk("blocked_push", 64'(push_a), 64'd0);
        chk("blocked_busy", 64'(busy_a), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_push", 64'(push_a), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_drop", 64'(drop_b), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        full  = 4'b0;
        ptr_m   = '{3, 3};
        drops_m = '{0, 0};
        repeat (3) begin
            @(posedge clk); #1;
            chk("after_rst_push", 64'(push_a), 64'd0);
            chk("after_rst_busy", 64'(busy_a), 64'd0);
        end
        txn(0, 4'hF, d, 4'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter_bcast.md
Name: bus_rr_arbiter_bcast

Overview:
- Parametrised successor to the single-bus generator/arbiter that serves drvrs device FIFO ports.
- Arbitrates pending packets by round-robin or fixed priority, pops one packet from the winner, and delivers it to one destination or to all others (broadcast).
- Honours per-destination backpressure (full) and drops misaddressed packets with a counter.
- Sits between the device FIFO interface (pndng/pop/D_pop, push/D_push) and the driver/monitor agents.

Parameters:
- drvrs, 4, number of device ports.
- pckg_sz, 16, packet width in bits (>= ID_W+1).
- ID_W, 8, destination ID field width, located at [pckg_sz-1 -: ID_W].
- BCAST_ID, 8'hFF, destination value meaning broadcast.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  device i holds a packet (FWFT: D_pop valid while high).
- D_pop  in  drvrs*pckg_sz  packed packet data from device i, slice [i*pckg_sz +: pckg_sz].
- full  in  drvrs  device i cannot accept a push this cycle.
- pop  out  drvrs  one-cycle pop strobe to the granted source.
- push  out  drvrs  push strobe to each destination.
- D_push  out  drvrs*pckg_sz  packed data to destinations; every slice carries the captured packet.
- busy  out  1  high whenever state != IDLE.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
Reset:
- All outputs 0, state IDLE, RR pointer = drvrs-1 (so port 0 is first), captured packet cleared.
- Reset mid-transaction abandons the packet; an already-popped packet is lost by design.

FSM states: IDLE, POP, DELIVER.
- IDLE: if any pndng, compute grant and register it; go to POP.
  - RR mode: first pending index after the pointer, with wrap-around.
  - Fixed mode: lowest pending index.
- POP: pop[g]=1 for exactly one cycle; capture D_pop slice g at the same edge.
  - Decode the destination field.
  - dest == BCAST_ID: target mask = all ones except bit g.
  - dest < drvrs: target mask = onehot(dest). dest == g is allowed (self-delivery).
  - Otherwise: drop. drop_cnt += 1 (saturates at all-ones); return to IDLE.
  - On a valid destination, go to DELIVER.
  - RR pointer <= g, updated in POP.
- DELIVER:
  - push[i] = mask[i] & ~full[i]; D_push holds the packet.
  - Clear mask bits as they are pushed.
  - When the remaining mask becomes 0, go to IDLE. Targets may complete in different cycles.
  - No push pulse is repeated to the same target.
- Broadcast with drvrs == 1 gives an empty mask: counted as complete, not a drop; POP goes straight to IDLE.

Timing and throughput:
- Minimum latency from pndng seen in IDLE: pop in the next cycle, push one cycle later.
- A transaction takes 3 cycles unblocked; one packet at a time.
- pndng changes outside IDLE are ignored; the grant is stable through POP.
- pop never asserts outside POP; push never asserts outside DELIVER.
- pop is one-hot or zero; push is zero in IDLE/POP.

Decomposition:
- Package bus_arb_pkg:
  - state enum (IDLE, POP, DELIVER);
  - default BCAST_ID;
  - ID field extraction function;
  - onehot-to-index function.
- Sub-module rr_grant:
  - combinational pending + pointer + mode -> onehot grant and index;
  - reused by the next multi-bus variant.

Test Plan:
1. Reset held 5 cycles with pndng=4'b1111 -> pop, push, busy, drop_cnt all 0 throughout; first grant after release is port 0.
2. Port 1 sends 16'h02AB (drvrs=4) -> pop[1] for 1 cycle; next cycle push=4'b0100 with D_push slice 2 = 16'h02AB; busy drops after 3 cycles.
3. RR mode, pndng=4'b1111 held for 4 packets -> grant order 0,1,2,3, then wraps to 0. PRIO_MODE=1 with the same stimulus -> always 0.
4. Port 0 broadcasts 16'hFF55 with full=4'b0100 for 4 cycles -> push=4'b1010 in the first DELIVER cycle, push=4'b0100 once full[2] drops; no double pushes; then IDLE.
5. Port 3 sends dest 8'h07 -> pop[3] once, no push, drop_cnt=1. 65536 such packets with CNT_W=16 -> drop_cnt stays at 16'hFFFF.
6. reset asserted during DELIVER with full held high -> next cycle push=0, state IDLE, packet not delivered after reset release.
